game_turn_ctrl: RTL and testbench

Sequences one game of the 8x8 board. Clears board RAM at game start and accepts move requests from the input handler. Drives game_judger through its en/done handshake, writes accepted stones into board RAM, alternates sides and declares win or draw. Sits between the input/keypad logic and the game_judger/board-RAM pair; the judger owns the RAM read port, this block owns the write port.

---
 rtl/game_turn_ctrl_if.sv | 52 +++++
 rtl/game_turn_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_turn_ctrl_if.sv
// Shared side/judger encodings, plus the bus bundle that connects game_turn_ctrl
// to the input handler, the game_judger and the board-RAM write port.
`ifndef SIDE_RED
`define SIDE_RED 1'b0
`endif
`ifndef SIDE_GREEN
`define SIDE_GREEN 1'b1
`endif
`ifndef JUDGER_INVALID
`define JUDGER_INVALID 2'd0
`endif
`ifndef JUDGER_VALID
`define JUDGER_VALID 2'd1
`endif
`ifndef JUDGER_WIN
`define JUDGER_WIN 2'd2
`endif

interface game_turn_ctrl_if;
    // move request handshake with the input handler
    logic       move_valid;
    logic [5:0] move_pos;
    logic       move_ready;
    logic       move_ack;
    logic [1:0] move_status;
    // game_judger en/done handshake
    logic       judge_en;
    logic       judge_color;
    logic [5:0] judge_pos;
    logic [1:0] judge_result;
    logic       judge_done;
    // board RAM write port
    logic       ram_we;
    logic [5:0] ram_wr_addr;
    logic [1:0] ram_wr_data;

    // controller view
    modport master (
        input  move_valid, move_pos, judge_result, judge_done,
        output move_ready, move_ack, move_status,
        output judge_en, judge_color, judge_pos,
        output ram_we, ram_wr_addr, ram_wr_data
    );

    // environment view (input handler, judger, RAM)
    modport slave (
        output move_valid, move_pos, judge_result, judge_done,
        input  move_ready, move_ack, move_status,
        input  judge_en, judge_color, judge_pos,
        input  ram_we, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for one game on the 8x8 board: clears the board RAM,
// accepts moves, drives the judger, writes stones and declares win/draw.
module game_turn_ctrl #(
    parameter logic FIRST_SIDE = `SIDE_RED,
    parameter int   TIMEOUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_game,
    game_turn_ctrl_if.master  bus,
    output logic              cur_side,
    output logic [6:0]        move_count,
    output logic              game_over,
    output logic              winner_valid,
    output logic              winner_side,
    output logic              judge_timeout
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_JUDGE,
        S_RELEASE,
        S_WRITE,
        S_ACK,
        S_OVER
    } state_t;

    state_t               state_reg, state_next;
    logic [5:0]           clr_addr_reg, clr_addr_next;
    logic [5:0]           pos_reg, pos_next;
    logic [1:0]           result_reg, result_next;
    logic [TIMEOUT_W-1:0] wd_reg, wd_next;
    logic                 side_reg, side_next;
    logic [6:0]           count_reg, count_next;
    logic                 win_valid_reg, win_valid_next;
    logic                 win_side_reg, win_side_next;
    logic                 timeout_reg, timeout_next;

    // State and datapath registers; reset aborts any judge in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_CLEAR;
            clr_addr_reg  <= 6'd0;
            pos_reg       <= 6'd0;
            result_reg    <= `JUDGER_INVALID;
            wd_reg        <= '0;
            side_reg      <= FIRST_SIDE;
            count_reg     <= 7'd0;
            win_valid_reg <= 1'b0;
            win_side_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_addr_reg  <= clr_addr_next;
            pos_reg       <= pos_next;
            result_reg    <= result_next;
            wd_reg        <= wd_next;
            side_reg      <= side_next;
            count_reg     <= count_next;
            win_valid_reg <= win_valid_next;
            win_side_reg  <= win_side_next;
            timeout_reg   <= timeout_next;
        end
    end

    // Next-state and output decode for the turn sequence.
    always_comb begin
        state_next       = state_reg;
        clr_addr_next    = clr_addr_reg;
        pos_next         = pos_reg;
        result_next      = result_reg;
        wd_next          = wd_reg;
        side_next        = side_reg;
        count_next       = count_reg;
        win_valid_next   = win_valid_reg;
        win_side_next    = win_side_reg;
        timeout_next     = timeout_reg;
        bus.move_ready   = 1'b0;
        bus.move_ack     = 1'b0;
        bus.move_status  = 2'b00;
        bus.judge_en     = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_wr_addr  = 6'd0;
        bus.ram_wr_data  = 2'b00;

        case (state_reg)
            S_CLEAR: begin
                bus.ram_we      = 1'b1;
                bus.ram_wr_addr = clr_addr_reg;
                clr_addr_next   = clr_addr_reg + 6'd1;
                if (clr_addr_reg == 6'd63) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                bus.move_ready = 1'b1;
                if (new_game) begin
                    state_next     = S_CLEAR;
                    clr_addr_next  = 6'd0;
                    side_next      = FIRST_SIDE;
                    count_next     = 7'd0;
                    win_valid_next = 1'b0;
                    timeout_next   = 1'b0;
                end else if (bus.move_valid) begin
                    pos_next   = bus.move_pos;
                    wd_next    = '0;
                    state_next = S_JUDGE;
                end
            end
            S_JUDGE: begin
                bus.judge_en = 1'b1;
                // done wins over the watchdog when both land in the same cycle
                if (bus.judge_done) begin
                    result_next = bus.judge_result;
                    state_next  = S_RELEASE;
                end else if (wd_reg == {TIMEOUT_W{1'b1}}) begin
                    timeout_next = 1'b1;
                    result_next  = `JUDGER_INVALID;
                    state_next   = S_RELEASE;
                end else begin
                    wd_next = wd_reg + TIMEOUT_W'(1);
                end
            end
            S_RELEASE: begin
                // hold en low until the judger drops done so it can re-arm
                if (!bus.judge_done) begin
                    if (result_reg == `JUDGER_VALID || result_reg == `JUDGER_WIN) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_ACK;
                    end
                end
            end
            S_WRITE: begin
                bus.ram_we      = 1'b1;
                bus.ram_wr_addr = pos_reg;
                bus.ram_wr_data = (side_reg == `SIDE_RED) ? 2'b10 : 2'b01;
                state_next      = S_ACK;
            end
            S_ACK: begin
                bus.move_ack = 1'b1;
                if (result_reg == `JUDGER_WIN) begin
                    bus.move_status = 2'b10;
                    win_valid_next  = 1'b1;
                    win_side_next   = side_reg;
                    count_next      = count_reg + 7'd1;
                    state_next      = S_OVER;
                end else if (result_reg == `JUDGER_VALID) begin
                    count_next = count_reg + 7'd1;
                    if (count_reg == 7'd63) begin
                        // board full: draw
                        bus.move_status = 2'b11;
                        state_next      = S_OVER;
                    end else begin
                        bus.move_status = 2'b00;
                        side_next       = ~side_reg;
                        state_next      = S_IDLE;
                    end
                end else begin
                    bus.move_status = 2'b01;
                    state_next      = S_IDLE;
                end
            end
            S_OVER: begin
                if (new_game) begin
                    state_next     = S_CLEAR;
                    clr_addr_next  = 6'd0;
                    side_next      = FIRST_SIDE;
                    count_next     = 7'd0;
                    win_valid_next = 1'b0;
                    timeout_next   = 1'b0;
                end
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
    end

    assign bus.judge_color = side_reg;
    assign bus.judge_pos   = pos_reg;
    assign cur_side        = side_reg;
    assign move_count      = count_reg;
    assign game_over       = (state_reg == S_OVER);
    assign winner_valid    = win_valid_reg;
    assign winner_side     = win_side_reg;
    assign judge_timeout   = timeout_reg;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Bench for game_turn_ctrl: directed move sequences against a judger model,
// with a transaction-level game model and a per-cycle compare process.
`timescale 1ns/1ps
`ifndef SIDE_RED
`define SIDE_RED 1'b0
`endif
`ifndef SIDE_GREEN
`define SIDE_GREEN 1'b1
`endif
`ifndef JUDGER_INVALID
`define JUDGER_INVALID 2'd0
`endif
`ifndef JUDGER_VALID
`define JUDGER_VALID 2'd1
`endif
`ifndef JUDGER_WIN
`define JUDGER_WIN 2'd2
`endif

module tb_game_turn_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       cur_side;
    logic [6:0] move_count;
    logic       game_over;
    logic       winner_valid;
    logic       winner_side;
    logic       judge_timeout;

    game_turn_ctrl_if bus ();

    game_turn_ctrl #(.FIRST_SIDE(`SIDE_RED), .TIMEOUT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .new_game      (new_game),
        .bus           (bus),
        .cur_side      (cur_side),
        .move_count    (move_count),
        .game_over     (game_over),
        .winner_valid  (winner_valid),
        .winner_side   (winner_side),
        .judge_timeout (judge_timeout)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_fail = 0;

    // game model
    logic       exp_side;
    int         exp_count;
    bit         exp_over;
    bit         exp_winv;
    logic       exp_wins;
    bit         exp_to;
    logic [5:0] cur_pos;
    logic [7:0] wq[$];   // expected RAM writes {addr, data}
    logic [1:0] sq[$];   // expected move_status values

    // judger model
    logic [1:0] j_res = `JUDGER_INVALID;
    int         j_lat = 0;
    bit         j_nodone = 1'b0;
    int         j_cnt = 0;
    logic       j_done = 1'b0;

    assign bus.judge_result = j_res;
    assign bus.judge_done   = j_done;

    initial begin
        bus.move_valid = 1'b0;
        bus.move_pos   = 6'd0;
    end

    // done rises after j_lat cycles of en and holds until en drops
    always @(posedge clk) begin
        if (rst || !bus.judge_en) begin
            j_done <= 1'b0;
            j_cnt  <= 0;
        end else if (!j_nodone) begin
            if (j_cnt >= j_lat) j_done <= 1'b1;
            else                j_cnt  <= j_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // per-cycle compare: every write, every ack and the judge window fields
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we) begin
                if (wq.size() == 0) begin
                    tests_run++;
                    tests_fail++;
                    $display("FAIL ram_write: unexpected write addr %0d data %b", bus.ram_wr_addr, bus.ram_wr_data);
                end else begin
                    chk("ram_write", {24'd0, bus.ram_wr_addr, bus.ram_wr_data}, {24'd0, wq.pop_front()});
                end
            end
            if (bus.move_ack) begin
                if (sq.size() == 0) begin
                    tests_run++;
                    tests_fail++;
                    $display("FAIL move_ack: unexpected ack status %b", bus.move_status);
                end else begin
                    chk("move_status", {30'd0, bus.move_status}, {30'd0, sq.pop_front()});
                end
            end
            if (bus.judge_en) begin
                chk("judge_color", {31'd0, bus.judge_color}, {31'd0, exp_side});
                chk("judge_pos", {26'd0, bus.judge_pos}, {26'd0, cur_pos});
            end
        end
    end

    task automatic model_clear();
        exp_side  = `SIDE_RED;
        exp_count = 0;
        exp_over  = 1'b0;
        exp_winv  = 1'b0;
        exp_to    = 1'b0;
        for (int a = 0; a < 64; a++) wq.push_back({a[5:0], 2'b00});
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cur_side"}, {31'd0, cur_side}, {31'd0, exp_side});
        chk({tag, "_move_count"}, {25'd0, move_count}, exp_count);
        chk({tag, "_game_over"}, {31'd0, game_over}, {31'd0, exp_over});
        chk({tag, "_winner_valid"}, {31'd0, winner_valid}, {31'd0, exp_winv});
        if (exp_winv) chk({tag, "_winner_side"}, {31'd0, winner_side}, {31'd0, exp_wins});
        chk({tag, "_judge_timeout"}, {31'd0, judge_timeout}, {31'd0, exp_to});
        chk({tag, "_move_ready"}, {31'd0, bus.move_ready}, {31'd0, !exp_over});
        chk({tag, "_queues_drained"}, wq.size() + sq.size(), 0);
    endtask

    // count cycles from the first clear cycle until move_ready
    task automatic wait_clear(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.move_ready && n < 200);
        chk({tag, "_ready_cycle"}, n, 65);
        @(posedge clk); #1;
        check_state(tag);
        $display("[TB] clear %s ready on cycle %0d", tag, n);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        wq.delete();
        sq.delete();
        model_clear();
        #1 rst = 1'b0;
        wait_clear(tag);
    endtask

    task automatic do_new_game(input bit with_move, input string tag);
        @(negedge clk);
        model_clear();
        new_game = 1'b1;
        bus.move_valid = with_move;
        bus.move_pos = 6'd9;
        @(posedge clk); #1;
        new_game = 1'b0;
        bus.move_valid = 1'b0;
        wait_clear(tag);
    endtask

    task automatic do_move(input logic [5:0] pos, input logic [1:0] res, input int lat,
                           input bit nodone, input string tag);
        logic [1:0] eff;
        logic [1:0] st;
        logic       n_side;
        int         n_count;
        bit         n_over, n_winv;
        logic       n_wins;
        int         n = 0;
        int         en_cycles = 0;
        bit         acked = 1'b0;

        eff = nodone ? `JUDGER_INVALID : res;
        n_side = exp_side; n_count = exp_count; n_over = exp_over;
        n_winv = exp_winv; n_wins = exp_wins;
        if (eff == `JUDGER_WIN) begin
            st = 2'b10; n_count = exp_count + 1; n_over = 1'b1;
            n_winv = 1'b1; n_wins = exp_side;
        end else if (eff == `JUDGER_VALID) begin
            n_count = exp_count + 1;
            if (n_count == 64) begin
                st = 2'b11; n_over = 1'b1;
            end else begin
                st = 2'b00; n_side = ~exp_side;
            end
        end else begin
            st = 2'b01;
        end
        if (eff == `JUDGER_WIN || eff == `JUDGER_VALID)
            wq.push_back({pos, (exp_side == `SIDE_RED) ? 2'b10 : 2'b01});
        sq.push_back(st);

        do begin
            @(negedge clk);
            n++;
        end while (!bus.move_ready && n < 200);
        chk({tag, "_ready_wait"}, {31'd0, bus.move_ready}, 32'd1);
        j_res = res; j_lat = lat; j_nodone = nodone; cur_pos = pos;
        bus.move_valid = 1'b1;
        bus.move_pos = pos;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        for (int i = 0; i < 1000 && !acked; i++) begin
            @(negedge clk);
            if (bus.judge_en) en_cycles++;
            if (bus.move_ack) acked = 1'b1;
        end
        chk({tag, "_ack_seen"}, {31'd0, acked}, 32'd1);
        if (nodone) chk({tag, "_watchdog_cycles"}, en_cycles, 256);
        exp_side = n_side; exp_count = n_count; exp_over = n_over;
        exp_winv = n_winv; exp_wins = n_wins;
        if (nodone) exp_to = 1'b1;
        @(posedge clk); #1;
        check_state(tag);
        $display("[TB] move %s pos=%0d res=%0d status=%b count=%0d side=%0d",
                 tag, pos, res, st, move_count, cur_side);
    endtask

    initial begin
        exp_side = `SIDE_RED; exp_count = 0; exp_over = 0; exp_winv = 0;
        exp_wins = 1'b0; exp_to = 0; cur_pos = 6'd0;

        // reset, full board clear
        do_reset("reset");
        chk("pin_reset_side", {31'd0, cur_side}, 32'd0);
        chk("pin_reset_count", {25'd0, move_count}, 32'd0);

        // first red stone at 6'o33 = cell 27
        do_move(6'o33, `JUDGER_VALID, 0, 1'b0, "first");
        chk("pin_first_side_green", {31'd0, cur_side}, 32'd1);
        chk("pin_first_count", {25'd0, move_count}, 32'd1);

        // green tries the occupied cell
        do_move(6'o33, `JUDGER_INVALID, 2, 1'b0, "occupied");
        chk("pin_occupied_count", {25'd0, move_count}, 32'd1);

        // alternate until red places its fifth stone and wins
        do_move(6'd0,  `JUDGER_VALID, 1, 1'b0, "g1");
        do_move(6'd1,  `JUDGER_VALID, 3, 1'b0, "r2");
        do_move(6'd8,  `JUDGER_VALID, 0, 1'b0, "g2");
        do_move(6'd2,  `JUDGER_VALID, 2, 1'b0, "r3");
        do_move(6'd16, `JUDGER_VALID, 1, 1'b0, "g3");
        do_move(6'd3,  `JUDGER_VALID, 0, 1'b0, "r4");
        do_move(6'd24, `JUDGER_VALID, 4, 1'b0, "g4");
        do_move(6'd4,  `JUDGER_WIN,   1, 1'b0, "r5_win");
        chk("pin_win_count", {25'd0, move_count}, 32'd9);
        chk("pin_win_side", {31'd0, winner_side}, 32'd0);

        // moves in S_OVER are ignored
        bus.move_valid = 1'b1;
        bus.move_pos = 6'd40;
        j_res = `JUDGER_VALID;
        repeat (6) @(posedge clk);
        #1 bus.move_valid = 1'b0;
        check_state("over_ignore");

        // restart clears the winner
        do_new_game(1'b0, "restart");

        // judger never answers: watchdog
        do_move(6'd10, `JUDGER_VALID, 0, 1'b1, "timeout");
        chk("pin_timeout_flag", {31'd0, judge_timeout}, 32'd1);

        // 64 accepted moves fill the board: draw
        for (int p = 0; p < 64; p++) begin
            do_move(p[5:0], `JUDGER_VALID, p % 3, 1'b0, $sformatf("fill%0d", p));
        end
        chk("pin_draw_count", {25'd0, move_count}, 32'd64);
        chk("pin_draw_over", {31'd0, game_over}, 32'd1);

        do_new_game(1'b0, "after_draw");

        // reset while the judge is active
        j_nodone = 1'b1;
        j_res = `JUDGER_VALID;
        cur_pos = 6'd5;
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_pos = 6'd5;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midjudge_en_before", {31'd0, bus.judge_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midjudge_en_after", {31'd0, bus.judge_en}, 32'd0);
        chk("midjudge_clear_we", {31'd0, bus.ram_we}, 32'd1);
        chk("midjudge_clear_addr", {26'd0, bus.ram_wr_addr}, 32'd0);
        j_nodone = 1'b0;
        do_reset("midjudge_reset");

        // new_game beats move_valid in S_IDLE
        do_move(6'd20, `JUDGER_VALID, 0, 1'b0, "pre_ng");
        do_new_game(1'b1, "ng_priority");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

    // global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
